peripheral_mpram_ahb4_initiator: RTL and testbench



---
 rtl/peripheral_ahb4_pkg.sv | 23 ++
 rtl/peripheral_mpram_ahb4_initiator_if.sv | 44 ++++
 rtl/peripheral_mpram_ahb4_initiator.sv | 127 ++++++++++++
 tb/tb_peripheral_mpram_ahb4_initiator.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/peripheral_ahb4_pkg.sv
// Shared AHB4 (AHB-Lite subset) encodings and the initiator FSM state type,
// used by both the MPRAM AHB4 initiator and slave.
package peripheral_ahb4_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } ahb4_init_state_e;

endpackage

// File: rtl/peripheral_mpram_ahb4_initiator_if.sv
// Request/response port plus AHB-Lite bus signals of the MPRAM AHB4 initiator.
// master = initiator side, slave = requester/bus-slave side.
interface peripheral_mpram_ahb4_initiator_if #(
    parameter int PLEN = 8,
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [PLEN-1:0] req_addr;
    logic [2:0]      req_size;
    logic [XLEN-1:0] req_wdata;

    logic            rsp_valid;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_error;

    logic [PLEN-1:0] HADDR;
    logic [XLEN-1:0] HWDATA;
    logic            HWRITE;
    logic [2:0]      HSIZE;
    logic [2:0]      HBURST;
    logic [3:0]      HPROT;
    logic [1:0]      HTRANS;
    logic            HMASTLOCK;
    logic [XLEN-1:0] HRDATA;
    logic            HREADY;
    logic            HRESP;

    modport master (
        input  req_valid, req_write, req_addr, req_size, req_wdata,
        input  HRDATA, HREADY, HRESP,
        output req_ready, rsp_valid, rsp_rdata, rsp_error,
        output HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK
    );

    modport slave (
        output req_valid, req_write, req_addr, req_size, req_wdata,
        output HRDATA, HREADY, HRESP,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error,
        input  HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK
    );

endinterface

// File: rtl/peripheral_mpram_ahb4_initiator.sv
// Single-outstanding AHB-Lite initiator: one valid/ready request becomes one
// non-pipelined SINGLE transfer, answered by a one-cycle response strobe.
module peripheral_mpram_ahb4_initiator
    import peripheral_ahb4_pkg::*;
#(
    parameter int         PLEN        = 8,
    parameter int         XLEN        = 32,
    parameter logic [3:0] HPROT_VALUE = 4'b0011
) (
    input logic                          HCLK,
    input logic                          HRESET,
    peripheral_mpram_ahb4_initiator_if.master bus
);

    ahb4_init_state_e state;
    ahb4_init_state_e state_nxt;

    logic            write_q;
    logic [PLEN-1:0] addr_q;
    logic [2:0]      size_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] rdata_q;
    logic            error_q;

    logic            req_ready;
    logic            rsp_valid;
    logic [1:0]      htrans;
    logic            accept;
    logic            req_legal;

    function automatic logic is_legal(input logic [2:0] size, input logic [1:0] lsb);
        logic ok;
        case (size)
            HSIZE_BYTE: ok = 1'b1;
            HSIZE_HALF: ok = ~lsb[0];
            HSIZE_WORD: ok = (lsb == 2'b00);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign req_legal = is_legal(bus.req_size, bus.req_addr[1:0]);
    assign accept    = (state == ST_IDLE) && bus.req_valid;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Handshake and HTRANS are decoded from state only, never from inputs.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        htrans    = HTRANS_IDLE;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_nxt = req_legal ? ST_ADDR : ST_RESP;
                end
            end
            ST_ADDR: begin
                htrans = HTRANS_NONSEQ;
                if (bus.HREADY) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bus.HREADY) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            size_q  <= HSIZE_WORD;
            wdata_q <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            if (accept) begin
                write_q <= bus.req_write;
                addr_q  <= bus.req_addr;
                size_q  <= bus.req_size;
                wdata_q <= bus.req_wdata;
                if (!req_legal) begin
                    rdata_q <= '0;
                    error_q <= 1'b1;
                end
            end
            // HRESP is sampled only on the completing cycle; the first error
            // cycle (HREADY=0) is absorbed as an ordinary wait state.
            if ((state == ST_DATA) && bus.HREADY) begin
                rdata_q <= write_q ? '0 : bus.HRDATA;
                error_q <= bus.HRESP;
            end
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_error = error_q;

    assign bus.HADDR     = addr_q;
    assign bus.HWDATA    = wdata_q;
    assign bus.HWRITE    = write_q;
    assign bus.HSIZE     = size_q;
    assign bus.HBURST    = HBURST_SINGLE;
    assign bus.HPROT     = HPROT_VALUE;
    assign bus.HTRANS    = htrans;
    assign bus.HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_peripheral_mpram_ahb4_initiator.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and
// randomized transfers against an MPRAM slave model and a reference memory.
module tb_peripheral_mpram_ahb4_initiator;
    import peripheral_ahb4_pkg::*;

    localparam int PLEN = 8;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    peripheral_mpram_ahb4_initiator_if #(.PLEN(PLEN), .XLEN(XLEN)) bus ();

    peripheral_mpram_ahb4_initiator #(
        .PLEN(PLEN),
        .XLEN(XLEN),
        .HPROT_VALUE(4'b0011)
    ) dut (
        .HCLK  (clk),
        .HRESET(rst),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [7:0] a, input logic [2:0] sz);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < (1 << sz); i++) begin
            int lane;
            lane = int'(a[1:0]) + i;
            r[lane*8 +: 8] = wd[lane*8 +: 8];
        end
        return r;
    endfunction

    // ---------------- MPRAM slave model ----------------
    logic [31:0] smem [64];
    logic [31:0] rmem [64];
    int          aw_left = 0;
    int          dw_cfg  = 0;
    bit          err_cfg = 0;
    bit          dp_active = 0;
    bit          dp_write;
    logic [7:0]  dp_addr;
    logic [2:0]  dp_size;
    int          w_left;
    bit          addr_acc_n = 0;
    bit          data_done_n = 0;
    logic [31:0] hwdata_n;
    logic [7:0]  haddr_n;
    logic        hwrite_n;
    logic [2:0]  hsize_n;

    int          nonseq_cnt = 0;
    logic [7:0]  exp_addr;
    logic        exp_write;
    logic [2:0]  exp_size;
    logic [31:0] exp_wdata;

    always @(negedge clk) begin
        addr_acc_n  = !rst && (bus.HTRANS == 2'b10) && bus.HREADY;
        data_done_n = !rst && dp_active && bus.HREADY;
        hwdata_n = bus.HWDATA;
        haddr_n  = bus.HADDR;
        hwrite_n = bus.HWRITE;
        hsize_n  = bus.HSIZE;
        if (!rst && bus.HTRANS == 2'b10) begin
            nonseq_cnt++;
            chk("haddr", 32'(bus.HADDR), 32'(exp_addr));
            chk("hwrite", 32'(bus.HWRITE), 32'(exp_write));
            chk("hsize", 32'(bus.HSIZE), 32'(exp_size));
            chk("hburst", 32'(bus.HBURST), 32'd0);
            chk("hprot", 32'(bus.HPROT), 32'h3);
            chk("hmastlock", 32'(bus.HMASTLOCK), 32'd0);
        end
        if (!rst && dp_active) begin
            chk("htrans_in_data", 32'(bus.HTRANS), 32'd0);
            if (dp_write) chk("hwdata", bus.HWDATA, exp_wdata);
        end
    end

    always @(posedge clk) begin
        #1;
        if (rst) begin
            dp_active   = 0;
            aw_left     = 0;
            addr_acc_n  = 0;
            data_done_n = 0;
            bus.HREADY  = 1'b1;
            bus.HRESP   = 1'b0;
            bus.HRDATA  = '0;
        end else begin
            if (data_done_n) begin
                if (dp_write && !err_cfg)
                    smem[dp_addr[7:2]] = merge(smem[dp_addr[7:2]], hwdata_n, dp_addr, dp_size);
                dp_active = 0;
            end
            if (addr_acc_n) begin
                dp_active = 1;
                dp_write  = hwrite_n;
                dp_addr   = haddr_n;
                dp_size   = hsize_n;
                w_left    = dw_cfg;
            end
            addr_acc_n  = 0;
            data_done_n = 0;
            if (dp_active) begin
                if (w_left > 0) begin
                    bus.HREADY = 1'b0;
                    bus.HRESP  = err_cfg && (w_left == 1);
                    bus.HRDATA = '0;
                    w_left--;
                end else begin
                    bus.HREADY = 1'b1;
                    bus.HRESP  = err_cfg;
                    bus.HRDATA = (err_cfg || dp_write) ? 32'd0 : smem[dp_addr[7:2]];
                end
            end else if (bus.HTRANS == 2'b10 && aw_left > 0) begin
                bus.HREADY = 1'b0;
                bus.HRESP  = 1'b0;
                bus.HRDATA = '0;
                aw_left--;
            end else begin
                bus.HREADY = 1'b1;
                bus.HRESP  = 1'b0;
                bus.HRDATA = '0;
            end
        end
    end

    // ---------------- reference model ----------------
    task automatic model(input logic wr, input logic [7:0] a, input logic [2:0] sz,
                         input logic [31:0] wd, input int aw, input int dw, input bit er,
                         output logic [31:0] rd, output bit re, output int lat, output int ns);
        bit legal;
        legal = (sz <= 3'd2) && ((int'(a) % (1 << sz)) == 0);
        if (!legal) begin
            rd = 0; re = 1; lat = 1; ns = 0;
        end else begin
            lat = 3 + aw + dw;
            ns  = 1 + aw;
            re  = er;
            rd  = (er || wr) ? 32'd0 : rmem[a[7:2]];
            if (wr && !er) rmem[a[7:2]] = merge(rmem[a[7:2]], wd, a, sz);
        end
    endtask

    // Caller must be at a negedge; returns at the negedge after the response.
    task automatic do_txn(input logic wr, input logic [7:0] a, input logic [2:0] sz,
                          input logic [31:0] wd, input int aw, input int dw, input bit er,
                          output logic [31:0] rd, output bit re, output int lat, output int ns);
        int guard;
        aw_left = aw; dw_cfg = dw; err_cfg = er;
        exp_addr = a; exp_write = wr; exp_size = sz; exp_wdata = wd;
        nonseq_cnt = 0;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_size  = sz;
        bus.req_wdata = wd;
        guard = 0;
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_wdata = $urandom;
        bus.req_addr  = 8'($urandom);
        lat = 1;
        while (!bus.rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.rsp_valid) chk("rsp_timeout", 32'd0, 32'd1);
        rd = bus.rsp_rdata;
        re = bus.rsp_error;
        ns = nonseq_cnt;
        @(negedge clk);
        chk("rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);
    endtask

    typedef struct {
        logic        wr;
        logic [7:0]  a;
        logic [2:0]  sz;
        logic [31:0] wd;
        int          aw;
        int          dw;
        bit          er;
        logic [31:0] x_rd;
        bit          x_re;
        int          x_lat;
        int          x_ns;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [12];
        logic [31:0] rd, m_rd;
        bit          re, m_re;
        int          lat, ns, m_lat, m_ns;
        bit          seen;

        for (int i = 0; i < 64; i++) begin
            smem[i] = '0;
            rmem[i] = '0;
        end
        bus.req_valid = 0; bus.req_write = 0; bus.req_addr = '0;
        bus.req_size = '0; bus.req_wdata = '0;

        vecs[0]  = '{1, 8'h10, 3'd2, 32'hDEADBEEF, 0, 0, 0, 32'h0,        0, 3, 1};
        vecs[1]  = '{0, 8'h10, 3'd2, 32'h0,        0, 2, 0, 32'hDEADBEEF, 0, 5, 1};
        vecs[2]  = '{0, 8'h10, 3'd2, 32'h0,        0, 1, 1, 32'h0,        1, 4, 1};
        vecs[3]  = '{1, 8'h03, 3'd1, 32'h12345678, 0, 0, 0, 32'h0,        1, 1, 0};
        vecs[4]  = '{0, 8'h12, 3'd2, 32'h0,        0, 0, 0, 32'h0,        1, 1, 0};
        vecs[5]  = '{0, 8'h00, 3'd3, 32'h0,        0, 0, 0, 32'h0,        1, 1, 0};
        vecs[6]  = '{1, 8'h13, 3'd0, 32'hAA000000, 0, 0, 0, 32'h0,        0, 3, 1};
        vecs[7]  = '{1, 8'h16, 3'd1, 32'h55660000, 0, 1, 0, 32'h0,        0, 4, 1};
        vecs[8]  = '{0, 8'h14, 3'd2, 32'h0,        2, 0, 0, 32'h55660000, 0, 5, 3};
        vecs[9]  = '{0, 8'h10, 3'd2, 32'h0,        0, 0, 0, 32'hAAADBEEF, 0, 3, 1};
        vecs[10] = '{1, 8'h18, 3'd2, 32'hCAFEF00D, 0, 1, 1, 32'h0,        1, 4, 1};
        vecs[11] = '{0, 8'h18, 3'd2, 32'h0,        1, 1, 0, 32'h0,        0, 5, 2};

        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_rsp_error", 32'(bus.rsp_error), 32'd0);
        chk("rst_haddr", 32'(bus.HADDR), 32'd0);
        chk("rst_hwdata", bus.HWDATA, 32'd0);
        chk("rst_hwrite", 32'(bus.HWRITE), 32'd0);
        chk("rst_hsize", 32'(bus.HSIZE), 32'd2);
        chk("rst_htrans", 32'(bus.HTRANS), 32'd0);
        chk("rst_hburst", 32'(bus.HBURST), 32'd0);
        chk("rst_hprot", 32'(bus.HPROT), 32'h3);
        chk("rst_hmastlock", 32'(bus.HMASTLOCK), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            model(vecs[i].wr, vecs[i].a, vecs[i].sz, vecs[i].wd, vecs[i].aw, vecs[i].dw,
                  vecs[i].er, m_rd, m_re, m_lat, m_ns);
            do_txn(vecs[i].wr, vecs[i].a, vecs[i].sz, vecs[i].wd, vecs[i].aw, vecs[i].dw,
                   vecs[i].er, rd, re, lat, ns);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].x_rd);
            chk($sformatf("vec%0d_error", i), 32'(re), 32'(vecs[i].x_re));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].x_lat));
            chk($sformatf("vec%0d_nonseq", i), 32'(ns), 32'(vecs[i].x_ns));
        end

        // Back-to-back: write 0x20 then a held read of 0x20.
        model(1, 8'h20, 3'd2, 32'h12345678, 0, 0, 0, m_rd, m_re, m_lat, m_ns);
        aw_left = 0; dw_cfg = 0; err_cfg = 0;
        exp_addr = 8'h20; exp_write = 1; exp_size = 3'd2; exp_wdata = 32'h12345678;
        nonseq_cnt = 0;
        bus.req_valid = 1; bus.req_write = 1; bus.req_addr = 8'h20;
        bus.req_size = 3'd2; bus.req_wdata = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        bus.req_write = 0; bus.req_wdata = 32'hFFFFFFFF;
        @(negedge clk);
        exp_write = 0;
        @(negedge clk);
        chk("b2b_rsp1_valid", 32'(bus.rsp_valid), 32'd1);
        chk("b2b_rsp1_error", 32'(bus.rsp_error), 32'd0);
        chk("b2b_busy_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        chk("b2b_ready_after_rsp", 32'(bus.req_ready), 32'd1);
        chk("b2b_no_rsp", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 0;
        repeat (2) @(negedge clk);
        chk("b2b_rsp2_valid", 32'(bus.rsp_valid), 32'd1);
        chk("b2b_rsp2_rdata", bus.rsp_rdata, 32'h12345678);
        chk("b2b_rsp2_error", 32'(bus.rsp_error), 32'd0);
        chk("b2b_nonseq", 32'(nonseq_cnt), 32'd2);
        @(negedge clk);

        // Reset while a read sits in its data phase.
        aw_left = 0; dw_cfg = 3; err_cfg = 0;
        exp_addr = 8'h10; exp_write = 0; exp_size = 3'd2;
        bus.req_valid = 1; bus.req_write = 0; bus.req_addr = 8'h10; bus.req_size = 3'd2;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_htrans", 32'(bus.HTRANS), 32'd0);
        chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1;
        end
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1;
        end
        chk("mid_rst_no_rsp", 32'(seen), 32'd0);
        model(0, 8'h10, 3'd2, 32'h0, 0, 0, 0, m_rd, m_re, m_lat, m_ns);
        do_txn(0, 8'h10, 3'd2, 32'h0, 0, 0, 0, rd, re, lat, ns);
        chk("post_rst_rdata", rd, m_rd);
        chk("post_rst_error", 32'(re), 32'(m_re));
        chk("post_rst_latency", 32'(lat), 32'(m_lat));

        // Randomized transfers against the reference memory.
        for (int i = 0; i < 80; i++) begin
            logic        wr;
            logic [7:0]  a;
            logic [2:0]  sz;
            logic [31:0] wd;
            int          aw, dw, r;
            bit          er;
            wr = 1'($urandom_range(0, 1));
            r  = $urandom_range(0, 9);
            sz = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd2 : 3'(4 + $urandom_range(0, 3));
            a  = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0 && sz <= 3'd2) a = a & ~8'((1 << sz) - 1);
            wd = $urandom;
            aw = $urandom_range(0, 2);
            dw = $urandom_range(0, 2);
            er = ($urandom_range(0, 7) == 0);
            if (er && dw == 0) dw = 1;
            model(wr, a, sz, wd, aw, dw, er, m_rd, m_re, m_lat, m_ns);
            do_txn(wr, a, sz, wd, aw, dw, er, rd, re, lat, ns);
            chk($sformatf("rnd%0d_rdata", i), rd, m_rd);
            chk($sformatf("rnd%0d_error", i), 32'(re), 32'(m_re));
            chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'(m_lat));
            chk($sformatf("rnd%0d_nonseq", i), 32'(ns), 32'(m_ns));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
